// File: rtl/code_lock_pkg.sv
// Shared types and width helpers for the sequential code lock.
package code_lock_pkg;

   typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_t;

   // Bits needed to hold down-counter values 0..n-1 (never less than one).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/code_lock_timer.sv
// Loadable down-counter that holds at zero and flags it.
module code_lock_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/seq_code_lock.sv
// Sequential code lock: full-length entry compare, timed unlock, fail counting and lockout.
// Optional inter-symbol timeout (adds timeout_pulse) enabled by defining CODE_LOCK_TIMEOUT_EN.
import code_lock_pkg::*;

module seq_code_lock #(
   parameter int                        SYM_W       = 4,
   parameter int                        CODE_LEN    = 4,
   parameter logic [CODE_LEN*SYM_W-1:0] RESET_CODE  = 16'h4321,
   parameter int                        MAX_FAIL    = 3,
   parameter int                        UNLOCK_CYC  = 8,
   parameter int                        LOCKOUT_CYC = 16,
   parameter int                        TIMEOUT_CYC = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sym_valid,
   input  logic [SYM_W-1:0]              sym,
   input  logic                          lock_req,
   input  logic                          code_load,
   input  logic [CODE_LEN*SYM_W-1:0]     code_in,
   output logic                          unlocked,
   output logic                          locked_out,
   output logic                          match_pulse,
   output logic                          fail_pulse,
   output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
`ifdef CODE_LOCK_TIMEOUT_EN
   output logic                          timeout_pulse,
`endif
   output logic                          entry_active
);

   localparam int CW    = CODE_LEN * SYM_W;
   localparam int IDX_W = cnt_w(CODE_LEN);
   localparam int FC_W  = $clog2(MAX_FAIL + 1);
   localparam int TMR_W = cnt_w(max2(UNLOCK_CYC, LOCKOUT_CYC));
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);
   localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAIL);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              mism_q, mism_d;
   logic [CW-1:0]     code_q, code_d;
   logic [FC_W-1:0]   fail_cnt_q, fail_cnt_d, fail_inc;
   logic              match_q, match_d, fail_q, fail_d, to_q, to_d;
   logic [SYM_W-1:0]  cur_sym;
   logic              sym_neq, timeout_hit;
   logic              tmr_load, tmr_dec, tmr_zero;
   logic [TMR_W-1:0]  tmr_val;

   assign cur_sym  = code_q[SYM_W*int'(idx_q) +: SYM_W];
   assign sym_neq  = (sym != cur_sym);
   assign fail_inc = (fail_cnt_q == FC_MAX) ? FC_MAX : fail_cnt_q + 1'b1;

   code_lock_timer #(.W(TMR_W)) u_state_tmr (
      .clk(clk), .reset(reset), .load(tmr_load), .load_val(tmr_val),
      .dec(tmr_dec), .zero(tmr_zero)
   );

`ifdef CODE_LOCK_TIMEOUT_EN
   localparam int TO_W = cnt_w(TIMEOUT_CYC);
   logic to_load, to_dec, to_zero;

   // Restarts on every accepted symbol; runs only while waiting inside an entry.
   assign to_load     = (state_q == IDLE && !code_load && sym_valid) || (state_q == ENTRY && sym_valid);
   assign to_dec      = (state_q == ENTRY) && !sym_valid;
   assign timeout_hit = to_dec && to_zero;

   code_lock_timer #(.W(TO_W)) u_gap_tmr (
      .clk(clk), .reset(reset), .load(to_load), .load_val(TO_W'(TIMEOUT_CYC - 1)),
      .dec(to_dec), .zero(to_zero)
   );

   assign timeout_pulse = to_q;
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         mism_q     <= 1'b0;
         code_q     <= RESET_CODE;
         fail_cnt_q <= '0;
         match_q    <= 1'b0;
         fail_q     <= 1'b0;
         to_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         mism_q     <= mism_d;
         code_q     <= code_d;
         fail_cnt_q <= fail_cnt_d;
         match_q    <= match_d;
         fail_q     <= fail_d;
         to_q       <= to_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mism_d     = mism_q;
      code_d     = code_q;
      fail_cnt_d = fail_cnt_q;
      match_d    = 1'b0;
      fail_d     = 1'b0;
      to_d       = 1'b0;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      tmr_dec    = 1'b0;
      case (state_q)
         IDLE: begin
            if (code_load) begin
               code_d = code_in;
            end else if (sym_valid) begin
               mism_d  = sym_neq;
               idx_d   = IDX_W'(1);
               state_d = ENTRY;
            end
         end
         ENTRY: begin
            if ((sym_valid && idx_q == LAST_IDX) || timeout_hit) begin
               idx_d  = '0;
               mism_d = 1'b0;
               if (!timeout_hit && !mism_q && !sym_neq) begin
                  match_d    = 1'b1;
                  fail_cnt_d = '0;
                  state_d    = OPEN;
                  tmr_load   = 1'b1;
                  tmr_val    = TMR_W'(UNLOCK_CYC - 1);
               end else begin
                  fail_d     = 1'b1;
                  to_d       = timeout_hit;
                  fail_cnt_d = fail_inc;
                  if (fail_inc == FC_MAX) begin
                     state_d  = LOCKOUT;
                     tmr_load = 1'b1;
                     tmr_val  = TMR_W'(LOCKOUT_CYC - 1);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else if (sym_valid) begin
               mism_d = mism_q | sym_neq;
               idx_d  = idx_q + 1'b1;
            end
         end
         OPEN: begin
            if (code_load)
               code_d = code_in;
            if (lock_req || tmr_zero)
               state_d = IDLE;
            else
               tmr_dec = 1'b1;
         end
         LOCKOUT: begin
            if (tmr_zero) begin
               state_d    = IDLE;
               fail_cnt_d = '0;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign unlocked     = (state_q == OPEN);
   assign locked_out   = (state_q == LOCKOUT);
   assign entry_active = (state_q == ENTRY);
   assign match_pulse  = match_q;
   assign fail_pulse   = fail_q;
   assign fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_seq_code_lock.sv
// Randomized bench for seq_code_lock against an entry-queue reference model.
module tb_seq_code_lock;

   localparam int SYM_W       = 4;
   localparam int CODE_LEN    = 4;
   localparam int MAX_FAIL    = 3;
   localparam int UNLOCK_CYC  = 8;
   localparam int LOCKOUT_CYC = 16;
   localparam int TIMEOUT_CYC = 32;
   localparam int CW          = CODE_LEN * SYM_W;
   localparam int FC_W        = $clog2(MAX_FAIL + 1);
   localparam logic [CW-1:0] RESET_CODE = 16'h4321;

   logic              clk = 1'b0;
   logic              reset, sym_valid, lock_req, code_load;
   logic [SYM_W-1:0]  sym;
   logic [CW-1:0]     code_in;
   logic              unlocked, locked_out, match_pulse, fail_pulse, entry_active;
   logic [FC_W-1:0]   fail_cnt;
`ifdef CODE_LOCK_TIMEOUT_EN
   logic              timeout_pulse;
`endif

   seq_code_lock #(
      .SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .RESET_CODE(RESET_CODE), .MAX_FAIL(MAX_FAIL),
      .UNLOCK_CYC(UNLOCK_CYC), .LOCKOUT_CYC(LOCKOUT_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym(sym), .lock_req(lock_req),
      .code_load(code_load), .code_in(code_in), .unlocked(unlocked), .locked_out(locked_out),
      .match_pulse(match_pulse), .fail_pulse(fail_pulse), .fail_cnt(fail_cnt),
`ifdef CODE_LOCK_TIMEOUT_EN
      .timeout_pulse(timeout_pulse),
`endif
      .entry_active(entry_active)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: remaining open/lockout cycles, consecutive failures,
   // and the symbols gathered so far for the entry in progress.
   int               m_open, m_lock, m_fails, m_gap;
   logic [CW-1:0]    m_code;
   logic [SYM_W-1:0] m_q[$];
   bit               e_match, e_fail, e_to;

   task automatic model_fail(input bit is_to);
      e_fail  = 1'b1;
      e_to    = is_to;
      m_fails = (m_fails < MAX_FAIL) ? m_fails + 1 : MAX_FAIL;
      if (m_fails == MAX_FAIL) m_lock = LOCKOUT_CYC;
   endtask

   task automatic model_step();
      bit ok;
      e_match = 1'b0;
      e_fail  = 1'b0;
      e_to    = 1'b0;
      if (reset) begin
         m_open = 0; m_lock = 0; m_fails = 0; m_gap = 0;
         m_code = RESET_CODE;
         m_q.delete();
      end else if (m_open > 0) begin
         if (code_load) m_code = code_in;
         m_open = lock_req ? 0 : m_open - 1;
      end else if (m_lock > 0) begin
         m_lock--;
         if (m_lock == 0) m_fails = 0;
      end else if (m_q.size() == 0) begin
         if (code_load) m_code = code_in;
         else if (sym_valid) begin
            m_q.push_back(sym);
            m_gap = 0;
         end
      end else if (sym_valid) begin
         m_q.push_back(sym);
         m_gap = 0;
         if (m_q.size() == CODE_LEN) begin
            ok = 1'b1;
            for (int i = 0; i < CODE_LEN; i++)
               if (m_q[i] !== m_code[i*SYM_W +: SYM_W]) ok = 1'b0;
            m_q.delete();
            if (ok) begin
               e_match = 1'b1;
               m_fails = 0;
               m_open  = UNLOCK_CYC;
            end else begin
               model_fail(1'b0);
            end
         end
      end
`ifdef CODE_LOCK_TIMEOUT_EN
      else begin
         m_gap++;
         if (m_gap == TIMEOUT_CYC) begin
            m_q.delete();
            model_fail(1'b1);
         end
      end
`endif
   endtask

   task automatic tick(input bit v, input logic [SYM_W-1:0] s, input bit lr,
                       input bit cl, input logic [CW-1:0] ci, input bit rs);
      sym_valid = v; sym = s; lock_req = lr; code_load = cl; code_in = ci; reset = rs;
      @(posedge clk);
      model_step();
      #1;
      check_val("unlocked",     32'(unlocked),     32'(m_open > 0));
      check_val("locked_out",   32'(locked_out),   32'(m_lock > 0));
      check_val("entry_active", 32'(entry_active), 32'(m_q.size() > 0));
      check_val("match_pulse",  32'(match_pulse),  32'(e_match));
      check_val("fail_pulse",   32'(fail_pulse),   32'(e_fail));
      check_val("fail_cnt",     32'(fail_cnt),     32'(m_fails));
`ifdef CODE_LOCK_TIMEOUT_EN
      check_val("timeout_pulse", 32'(timeout_pulse), 32'(e_to));
`endif
   endtask

   task automatic send(input logic [SYM_W-1:0] s);
      tick(1'b1, s, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic entry4(input logic [SYM_W-1:0] a, b, c, d);
      send(a); send(b); send(c); send(d);
   endtask

   initial begin
      int r;
      logic [SYM_W-1:0] s;
      m_code = RESET_CODE;
      m_open = 0; m_lock = 0; m_fails = 0; m_gap = 0;
      tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      tick(1'b1, 4'h1, 1'b0, 1'b0, '0, 1'b1);
      // correct entry then full open window
      entry4(4'h1, 4'h2, 4'h3, 4'h4);
      idle(10);
      // three wrong entries -> lockout, symbols ignored inside it
      repeat (3) entry4(4'h1, 4'h2, 4'h9, 4'h4);
      entry4(4'h1, 4'h2, 4'h3, 4'h4);
      idle(14);
      // recovery after two failures
      entry4(4'h1, 4'h2, 4'h9, 4'h4);
      entry4(4'h1, 4'h2, 4'h9, 4'h4);
      entry4(4'h1, 4'h2, 4'h3, 4'h4);
      idle(9);
      // reload with a colliding symbol, then new and old code
      tick(1'b1, 4'h1, 1'b0, 1'b1, 16'h0A0B, 1'b0);
      entry4(4'hB, 4'h0, 4'hA, 4'h0);
      idle(9);
      entry4(4'h1, 4'h2, 4'h3, 4'h4);
      // early relock in the 3rd open cycle
      entry4(4'hB, 4'h0, 4'hA, 4'h0);
      idle(2);
      tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      idle(3);
      // reset mid-entry, then clean match on the reset code
      send(4'h1); send(4'h2);
      tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      entry4(4'h1, 4'h2, 4'h3, 4'h4);
      idle(9);
`ifdef CODE_LOCK_TIMEOUT_EN
      send(4'h1); send(4'h2);
      idle(TIMEOUT_CYC + 2);
`endif
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         s = (r < 65) ? m_code[(m_q.size() % CODE_LEN)*SYM_W +: SYM_W] : SYM_W'($urandom);
         if (r < 1)
            tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
         else if (r < 4)
            tick(1'($urandom), s, 1'b0, 1'b1, CW'($urandom), 1'b0);
         else if (r < 7)
            tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
         else if (r < 75)
            tick(1'b1, s, 1'b0, 1'b0, '0, 1'b0);
         else if (r < 77)
            idle(TIMEOUT_CYC);
         else
            tick(1'b0, s, 1'b0, 1'b0, '0, 1'b0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
